jt89_psg: RTL and testbench

Programmable sound generator compatible with the SN76489 register model: three square-wave tone channels and one LFSR noise channel. Each channel has a 4-bit logarithmic attenuator. The block is written byte-wise by a CPU bus and presents four signed 10-bit channel outputs for an external mixer. Its sound tick is derived from a clock-enable input.

---
 rtl/jt89_psg.sv | 183 ++++++++++++++++++
 tb/tb_jt89_psg.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/jt89_psg.sv
// jt89_psg: SN76489-style programmable sound generator.
// Three square-wave tone channels and one LFSR noise channel, each with a
// 4-bit logarithmic attenuator (2 dB steps, 15 = mute).
// Ports:
//   clk          system clock, all state changes on the rising edge
//   rst          asynchronous active-low reset
//   clken        enable for the sound prescaler (register writes ignore it)
//   wr_n         active-low write strobe, one write per low pulse
//   din[7:0]     write data byte (latch byte when din[7]=1, data byte otherwise)
//   ch0..ch2     signed 10-bit tone channel samples
//   noise        signed 10-bit noise channel sample
module jt89_psg (
  input  logic              clk,
  input  logic              rst,
  input  logic              clken,
  input  logic              wr_n,
  input  logic [7:0]        din,
  output logic signed [9:0] ch0,
  output logic signed [9:0] ch1,
  output logic signed [9:0] ch2,
  output logic signed [9:0] noise
);

  // Attenuation code to output magnitude.
  function automatic logic [9:0] att_level(input logic [3:0] att);
    case (att)
      4'd0:    att_level = 10'd511;
      4'd1:    att_level = 10'd406;
      4'd2:    att_level = 10'd322;
      4'd3:    att_level = 10'd256;
      4'd4:    att_level = 10'd203;
      4'd5:    att_level = 10'd162;
      4'd6:    att_level = 10'd128;
      4'd7:    att_level = 10'd102;
      4'd8:    att_level = 10'd81;
      4'd9:    att_level = 10'd64;
      4'd10:   att_level = 10'd51;
      4'd11:   att_level = 10'd41;
      4'd12:   att_level = 10'd32;
      4'd13:   att_level = 10'd26;
      4'd14:   att_level = 10'd20;
      default: att_level = 10'd0;
    endcase
  endfunction

  logic            wr_n_q, wr_n_d;
  logic [2:0]      latch_q, latch_d;     // {channel, is_attenuation}
  logic [3:0][3:0] att_q, att_d;
  logic [2:0][9:0] per_q, per_d;
  logic [2:0]      ctrl_q, ctrl_d;
  logic [3:0][9:0] cnt_q, cnt_d;         // index 3 is the noise-rate counter
  logic [3:0]      pol_q, pol_d;         // index 3 is the noise-rate square wave
  logic [15:0]     lfsr_q, lfsr_d;
  logic [3:0]      presc_q, presc_d;
  logic [3:0][9:0] out_q, out_d;

  logic            wr_s;
  logic            ctrl_wr_s;
  logic            tick_s;
  logic            lfsr_fb_s;
  logic [2:0]      sel_s;
  logic [3:0][9:0] reload_s;

  // Write decode: falling-edge detect on wr_n and register file update.
  always_comb begin
    wr_n_d    = wr_n;
    latch_d   = latch_q;
    att_d     = att_q;
    per_d     = per_q;
    ctrl_d    = ctrl_q;
    ctrl_wr_s = 1'b0;
    wr_s      = wr_n_q & ~wr_n;
    sel_s     = din[7] ? din[6:4] : latch_q;
    if (wr_s) begin
      if (din[7]) begin
        latch_d = din[6:4];
      end else begin
        latch_d = latch_q;
      end
      if (sel_s[0]) begin
        att_d[sel_s[2:1]] = din[3:0];
      end else begin
        case (sel_s[2:1])
          2'd3: begin
            ctrl_d    = din[2:0];
            ctrl_wr_s = 1'b1;
          end
          2'd0, 2'd1, 2'd2: begin
            // A latch byte carries the low nibble, a data byte the high six bits.
            if (din[7]) begin
              per_d[sel_s[2:1]][3:0] = din[3:0];
            end else begin
              per_d[sel_s[2:1]][9:4] = din[5:0];
            end
          end
          default: ctrl_wr_s = 1'b0;
        endcase
      end
    end else begin
      ctrl_wr_s = 1'b0;
    end
  end

  // Prescaler, channel counters, polarities and LFSR; uses freshly written registers.
  always_comb begin
    tick_s      = clken & (presc_q == 4'd15);
    presc_d     = clken ? (presc_q + 4'd1) : presc_q;
    reload_s[0] = per_d[0];
    reload_s[1] = per_d[1];
    reload_s[2] = per_d[2];
    case (ctrl_d[1:0])
      2'd0:    reload_s[3] = 10'd16;
      2'd1:    reload_s[3] = 10'd32;
      2'd2:    reload_s[3] = 10'd64;
      default: reload_s[3] = per_d[2];
    endcase
    cnt_d = cnt_q;
    pol_d = pol_q;
    for (int i = 0; i < 4; i++) begin
      if (tick_s) begin
        // Reloading at count 1 (or 0) gives a half-period of exactly 'period' ticks.
        if (cnt_q[i] <= 10'd1) begin
          cnt_d[i] = reload_s[i];
          pol_d[i] = (reload_s[i] <= 10'd1) ? 1'b1 : ~pol_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] - 10'd1;
        end
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
    lfsr_fb_s = ctrl_d[2] ? (lfsr_q[0] ^ lfsr_q[3]) : lfsr_q[0];
    if (ctrl_wr_s) begin
      lfsr_d = 16'h8000;
    end else if (~pol_q[3] & pol_d[3]) begin
      lfsr_d = {lfsr_fb_s, lfsr_q[15:1]};
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // Output samples from current polarity and attenuation.
  always_comb begin
    out_d = out_q;
    for (int i = 0; i < 3; i++) begin
      out_d[i] = pol_q[i] ? att_level(att_q[i]) : (10'd0 - att_level(att_q[i]));
    end
    out_d[3] = lfsr_q[0] ? att_level(att_q[3]) : (10'd0 - att_level(att_q[3]));
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_n_q  <= 1'b1;
      latch_q <= 3'd0;
      att_q   <= {4{4'hF}};
      per_q   <= '0;
      ctrl_q  <= 3'd0;
      cnt_q   <= '0;
      pol_q   <= 4'hF;
      lfsr_q  <= 16'h8000;
      presc_q <= 4'd0;
      out_q   <= '0;
    end else begin
      wr_n_q  <= wr_n_d;
      latch_q <= latch_d;
      att_q   <= att_d;
      per_q   <= per_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
      pol_q   <= pol_d;
      lfsr_q  <= lfsr_d;
      presc_q <= presc_d;
      out_q   <= out_d;
    end
  end

  assign ch0   = out_q[0];
  assign ch1   = out_q[1];
  assign ch2   = out_q[2];
  assign noise = out_q[3];

endmodule

// File: tb/tb_jt89_psg.sv
// Self-checking bench for jt89_psg: directed scenarios plus randomized
// writes / clken / resets, all compared cycle by cycle against a behavioural
// model of the register map, tone dividers and noise LFSR.
module tb_jt89_psg;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              clken = 1'b0;
  logic              wr_n = 1'b1;
  logic [7:0]        din = 8'h00;
  logic signed [9:0] ch0, ch1, ch2, noise;

  always #5 clk = ~clk;

  jt89_psg dut (
    .clk   (clk),
    .rst   (rst),
    .clken (clken),
    .wr_n  (wr_n),
    .din   (din),
    .ch0   (ch0),
    .ch1   (ch1),
    .ch2   (ch2),
    .noise (noise)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int lvl_tab[16] = '{511, 406, 322, 256, 203, 162, 128, 102, 81, 64, 51, 41, 32, 26, 20, 0};
  int m_att[4];
  int m_per[3];
  int m_ctrl, m_sel, m_lfsr, m_presc, m_wrprev;
  int m_cnt[4];
  int m_pol[4];
  int m_out[4];

  task automatic m_reset();
    for (int i = 0; i < 4; i++) begin
      m_att[i] = 15; m_cnt[i] = 0; m_pol[i] = 1; m_out[i] = 0;
    end
    for (int i = 0; i < 3; i++) m_per[i] = 0;
    m_ctrl = 0; m_sel = 0; m_lfsr = 'h8000; m_presc = 0; m_wrprev = 1;
  endtask

  task automatic m_step();
    int nout[4];
    int d, sel, ch, rel, newpol;
    bit tick, ctrl_wr, rising;
    if (!rst) begin
      m_reset();
      return;
    end
    for (int i = 0; i < 3; i++)
      nout[i] = m_pol[i] ? lvl_tab[m_att[i]] : -lvl_tab[m_att[i]];
    nout[3] = (m_lfsr & 1) ? lvl_tab[m_att[3]] : -lvl_tab[m_att[3]];
    tick = clken && (m_presc == 15);
    ctrl_wr = 0;
    rising = 0;
    d = int'(din);
    if (!wr_n && m_wrprev) begin
      sel = (d >= 128) ? ((d >> 4) & 7) : m_sel;
      if (d >= 128) m_sel = sel;
      ch = sel >> 1;
      if (sel & 1) m_att[ch] = d & 15;
      else if (ch == 3) begin m_ctrl = d & 7; ctrl_wr = 1; end
      else if (d >= 128) m_per[ch] = (m_per[ch] & 'h3F0) | (d & 15);
      else m_per[ch] = (m_per[ch] & 15) | ((d & 63) << 4);
    end
    m_wrprev = wr_n;
    if (tick) begin
      for (int i = 0; i < 4; i++) begin
        if (i < 3) rel = m_per[i];
        else if ((m_ctrl & 3) == 3) rel = m_per[2];
        else rel = 16 << (m_ctrl & 3);
        if (m_cnt[i] <= 1) begin
          m_cnt[i] = rel;
          newpol = (rel < 2) ? 1 : 1 - m_pol[i];
          if (i == 3 && m_pol[i] == 0 && newpol == 1) rising = 1;
          m_pol[i] = newpol;
        end else begin
          m_cnt[i] = m_cnt[i] - 1;
        end
      end
    end
    if (ctrl_wr) m_lfsr = 'h8000;
    else if (rising) begin
      int fb;
      fb = (m_ctrl & 4) ? ((m_lfsr ^ (m_lfsr >> 3)) & 1) : (m_lfsr & 1);
      m_lfsr = (m_lfsr >> 1) | (fb << 15);
    end
    if (clken) m_presc = (m_presc + 1) % 16;
    for (int i = 0; i < 4; i++) m_out[i] = nout[i];
  endtask

  // One clock: model advances with the DUT edge, outputs compared on the falling edge.
  task automatic cyc();
    @(posedge clk);
    m_step();
    @(negedge clk);
    check_val("ch0", ch0, m_out[0]);
    check_val("ch1", ch1, m_out[1]);
    check_val("ch2", ch2, m_out[2]);
    check_val("noise", noise, m_out[3]);
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic wr(input logic [7:0] b);
    din = b; wr_n = 1'b0; cyc();
    wr_n = 1'b1; cyc();
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Half-period of ch0 in clk cycles, measured from the last two sign changes.
  task automatic measure_ch0(input int cycles, input int clken_div, output int half);
    int t[$];
    bit last, s;
    last = (ch0 < 0);
    for (int c = 0; c < cycles; c++) begin
      clken = ((c % clken_div) == 0);
      cyc();
      s = (ch0 < 0);
      if (s != last) t.push_back(c);
      last = s;
    end
    clken = 1'b1;
    if (t.size() >= 2) half = t[t.size()-1] - t[t.size()-2];
    else half = -1;
  endtask

  initial begin
    int half;
    m_reset();
    @(negedge clk);
    // Reset: everything silent.
    clken = 1'b1;
    run(3);
    check_val("reset_ch0", ch0, 0);
    check_val("reset_noise", noise, 0);
    rst = 1'b1;
    run(10000);
    check_val("idle_ch0", ch0, 0);
    check_val("idle_ch2", ch2, 0);

    // Tone: ch0 period 0x010, att 0 -> 256 clk half-period at full scale.
    wr(8'h80); wr(8'h01); wr(8'h90);
    measure_ch0(800, 1, half);
    check_val("tone_half_period", half, 256);
    check_val("tone_mag", iabs(ch0), 511);

    // Attenuation sweep.
    for (int a = 1; a < 16; a++) begin
      wr(8'h90 | 8'(a));
      run(4);
      check_val("att_sweep_mag", iabs(ch0), lvl_tab[a]);
    end

    // wr_n held low 5 clk with din changing: only the first byte lands.
    din = 8'h90; wr_n = 1'b0; cyc();
    din = 8'h9F; run(4);
    wr_n = 1'b1; run(3);
    check_val("hold_single_write", iabs(ch0), 511);

    // Periodic noise clocked from ch2 (period 32).
    wr(8'hE3); wr(8'hF0); wr(8'hC0); wr(8'h02);
    run(3000);
    // White noise, then restart by rewriting the control register.
    wr(8'hE4);
    run(3000);
    wr(8'hE4);
    check_val("lfsr_restart_noise", noise, 0 - 511);
    run(2000);

    // Period 1 on ch1 at full scale -> held high.
    wr(8'hA1); wr(8'h00); wr(8'hB0);
    run(600);
    check_val("period1_ch1", ch1, 511);

    // clken 1 of 4 -> half-period stretched to 1024 clk.
    measure_ch0(5000, 4, half);
    check_val("clken_div4_half", half, 1024);

    // Asynchronous reset mid-operation clears the outputs at once.
    rst = 1'b0;
    #1;
    check_val("async_rst_ch0", ch0, 0);
    check_val("async_rst_ch1", ch1, 0);
    run(2);
    rst = 1'b1;
    run(5);

    // Randomized writes, strobe lengths, clken and occasional resets.
    for (int k = 0; k < 1500; k++) begin
      int hold;
      if ($urandom_range(0, 1) == 1) din = 8'($urandom_range(128, 255));
      else din = 8'($urandom_range(0, 15));
      hold = $urandom_range(1, 3);
      wr_n = 1'b0;
      for (int h = 0; h < hold; h++) begin
        clken = ($urandom_range(0, 3) != 0);
        if (h > 0) din = 8'($urandom_range(0, 255));
        cyc();
      end
      wr_n = 1'b1;
      for (int g = $urandom_range(1, 12); g > 0; g--) begin
        clken = ($urandom_range(0, 3) != 0);
        cyc();
      end
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0; cyc(); rst = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
